// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array skew feeder.
//   - default lane count, element width and beat-counter width
//   - feeder FSM state encoding
//   - drain length helper: cycles needed after the last beat until the
//     final partial sum reaches the far corner PE
package sa_pkg;

    localparam int SA_N     = 64;
    localparam int SA_WIDTH = 8;
    localparam int SA_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } sa_state_e;

    // The drain covers three parts. N-1 cycles for the deepest lane's skew,
    // 2*(N-1) cycles for array traversal, and 1 cycle for the output register.
    function automatic int drain_cyc(input int n);
        return 3 * (n - 1) + 1;
    endfunction

endpackage

// File: rtl/sa_lane_delay.sv
// Per-lane skew delay: a DEPTH-stage shift register of WIDTH-bit elements.
// Ports:
//   clk_i  clock
//   clr_i  synchronous clear of every stage (wins over en_i)
//   en_i   shift enable
//   d_i    element entering the line
//   q_o    element leaving the line, DEPTH cycles after it entered
module sa_lane_delay
    import sa_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // Newest element sits in the LS slice, oldest in the MS slice.
    logic [DEPTH*WIDTH-1:0] sr_q;
    logic [DEPTH*WIDTH-1:0] sr_d;

    generate
        if (DEPTH == 1) begin : g_single
            always_comb sr_d = d_i;
        end else begin : g_multi
            always_comb sr_d = {sr_q[(DEPTH-1)*WIDTH-1:0], d_i};
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sr_q <= '0;
        end else if (en_i) begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/sa_skew_feeder.sv
// Upstream feeder for the NxN systolic array. Accepts activation and weight
// beats over a valid/ready stream. It skews each beat diagonally, so lane i
// is delayed i cycles on top of the output register. It flushes the array
// with zeros after the last beat and pulses tile_done_o when the drain is
// complete.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           begin a tile (only honoured in IDLE)
//   in_valid_i/in_ready_o  beat handshake; ready only while streaming
//   act_vec_i, wgt_vec_i   beat payload, lane 0 in the MS slice
//   in_last_i         final beat of the tile
//   activation_o, weight_o skewed array inputs, lane 0 in the MS slice
//   control_o         array accumulate enable (STREAM and DRAIN)
//   busy_o            feeder not idle
//   beat_cnt_o        beats accepted in the current/last tile, saturating
//   tile_done_o       one-cycle completion pulse
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int N     = SA_N,
    parameter int WIDTH = SA_WIDTH,
    parameter int CNT_W = SA_CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [N*WIDTH-1:0] act_vec_i,
    input  logic [N*WIDTH-1:0] wgt_vec_i,
    input  logic               in_last_i,
    output logic [N*WIDTH-1:0] activation_o,
    output logic [N*WIDTH-1:0] weight_o,
    output logic               control_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   beat_cnt_o,
    output logic               tile_done_o
);

    localparam int DRAIN_CYC = drain_cyc(N);
    localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

    sa_state_e          state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               lane_clr;
    logic               lane_en;
    logic [N*WIDTH-1:0] act_lane_in;
    logic [N*WIDTH-1:0] wgt_lane_in;

    assign in_ready_o = (state_q == STREAM);
    assign accept     = in_valid_i && in_ready_o;

    // Anything not accepted enters the array as a zero bubble, which is MAC-neutral.
    assign act_lane_in = accept ? act_vec_i : '0;
    assign wgt_lane_in = accept ? wgt_vec_i : '0;

    // Holding the lines cleared in IDLE guarantees each tile starts from zeros.
    assign lane_clr = rst_i || (state_q == IDLE);
    assign lane_en  = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            drain_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (in_last_i) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_W'(DRAIN_CYC - 1);
                    end
                end
            end
            DRAIN: begin
                // Terminal count at zero gives exactly DRAIN_CYC cycles in DRAIN.
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign control_o   = (state_q == STREAM) || (state_q == DRAIN);
    assign busy_o      = (state_q != IDLE);
    assign tile_done_o = (state_q == DONE);
    assign beat_cnt_o  = cnt_q;

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            sa_lane_delay #(
                .DEPTH (i + 1),
                .WIDTH (WIDTH)
            ) u_act_dly (
                .clk_i (clk_i),
                .clr_i (lane_clr),
                .en_i  (lane_en),
                .d_i   (act_lane_in[(N-1-i)*WIDTH +: WIDTH]),
                .q_o   (activation_o[(N-1-i)*WIDTH +: WIDTH])
            );

            sa_lane_delay #(
                .DEPTH (i + 1),
                .WIDTH (WIDTH)
            ) u_wgt_dly (
                .clk_i (clk_i),
                .clr_i (lane_clr),
                .en_i  (lane_en),
                .d_i   (wgt_lane_in[(N-1-i)*WIDTH +: WIDTH]),
                .q_o   (weight_o[(N-1-i)*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder. The reference model records what
// entered the array on every cycle. It derives each lane's expected output
// from that history shifted by the lane's skew. It derives the control
// signals from the tile's start and last-beat timestamps.
module tb_sa_skew_feeder;

    localparam int N     = 64;
    localparam int W     = 8;
    localparam int CW    = 4;
    localparam int NW    = N * W;
    localparam int DRAIN = 3 * (N - 1) + 1;
    localparam int MAXC  = 8192;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] act_vec;
    logic [NW-1:0] wgt_vec;
    logic          in_last;
    logic [NW-1:0] activation;
    logic [NW-1:0] weight;
    logic          control;
    logic          busy;
    logic [CW-1:0] beat_cnt;
    logic          tile_done;

    sa_skew_feeder #(.N(N), .WIDTH(W), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .act_vec_i    (act_vec),
        .wgt_vec_i    (wgt_vec),
        .in_last_i    (in_last),
        .activation_o (activation),
        .weight_o     (weight),
        .control_o    (control),
        .busy_o       (busy),
        .beat_cnt_o   (beat_cnt),
        .tile_done_o  (tile_done)
    );

    always #5 clk = ~clk;

    // Reference model state
    int            n_vec = 0;
    int            n_mis = 0;
    int            cyc = 0;
    int            clr_cyc = 0;
    int            last_acc = -1000;
    bit            m_stream = 1'b0;
    int            m_cnt = 0;
    logic [NW-1:0] hist_a [MAXC];
    logic [NW-1:0] hist_w [MAXC];

    task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit            draining;
        bit            done;
        logic [NW-1:0] ea;
        logic [NW-1:0] ew;
        int            src;
        draining = (cyc >= last_acc + 1) && (cyc <= last_acc + DRAIN);
        done     = (cyc == last_acc + DRAIN + 1);
        ea = '0;
        ew = '0;
        for (int i = 0; i < N; i++) begin
            src = cyc - 1 - i;
            if (src > clr_cyc && src >= 0) begin
                ea[(N-1-i)*W +: W] = hist_a[src][(N-1-i)*W +: W];
                ew[(N-1-i)*W +: W] = hist_w[src][(N-1-i)*W +: W];
            end
        end
        chk("in_ready", NW'(in_ready), NW'(m_stream));
        chk("control", NW'(control), NW'(m_stream || draining));
        chk("busy", NW'(busy), NW'(m_stream || draining || done));
        chk("tile_done", NW'(tile_done), NW'(done));
        chk("beat_cnt", NW'(beat_cnt), NW'(m_cnt));
        chk("activation", activation, ea);
        chk("weight", weight, ew);
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input bit r, input bit s, input bit v, input bit l,
                        input logic [NW-1:0] a, input logic [NW-1:0] w);
        bit acc;
        bit idle;
        if (cyc >= MAXC - 2) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 2);
            $fatal(1, "cycle budget exhausted");
        end
        rst      = r;
        start    = s;
        in_valid = v;
        in_last  = l;
        act_vec  = a;
        wgt_vec  = w;
        acc = !r && m_stream && v;
        hist_a[cyc] = acc ? a : '0;
        hist_w[cyc] = acc ? w : '0;
        if (r) begin
            m_stream = 1'b0;
            m_cnt    = 0;
            last_acc = -1000;
            clr_cyc  = cyc;
        end else begin
            idle = !m_stream && (cyc > last_acc + DRAIN + 1);
            if (idle && s) begin
                m_stream = 1'b1;
                m_cnt    = 0;
            end else if (acc) begin
                if (m_cnt < (1 << CW) - 1) m_cnt++;
                if (l) begin
                    m_stream = 1'b0;
                    last_acc = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0, '0);
    endtask

    function automatic logic [NW-1:0] rand_vec();
        logic [NW-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic beat(input bit l);
        step(0, 0, 1, l, rand_vec(), rand_vec());
    endtask

    task automatic random_tile(input int len);
        int  k;
        bit  v;
        k = 0;
        step(0, 1, 0, 0, '0, '0);
        while (k < len) begin
            v = ($urandom_range(3) != 0);
            step(0, ($urandom_range(7) == 0), v, v && (k == len - 1), rand_vec(), rand_vec());
            if (v) k++;
        end
        for (int j = 0; j < DRAIN + 4; j++) begin
            step(0, ($urandom_range(15) == 0) && (j < DRAIN), 0, 0, '0, '0);
        end
    endtask

    initial begin
        logic [NW-1:0] a1;
        logic [NW-1:0] w1;

        // Reset held two cycles, then idle
        step(1, 0, 0, 0, '0, '0);
        step(1, 0, 0, 0, '0, '0);
        idle_n(3);

        // Single-beat tile with lane-indexed data
        for (int i = 0; i < N; i++) begin
            a1[(N-1-i)*W +: W] = W'(i + 1);
            w1[(N-1-i)*W +: W] = W'(8'h80 + i);
        end
        step(0, 1, 1, 0, a1, w1);       // start with in_valid: not accepted
        step(0, 0, 1, 1, a1, w1);
        idle_n(DRAIN + 4);

        // Four beats with a gap after beat 2
        step(0, 1, 0, 0, '0, '0);
        beat(0);
        beat(0);
        step(0, 0, 0, 0, rand_vec(), rand_vec());
        beat(0);
        beat(1);
        idle_n(DRAIN + 4);

        // start during STREAM and DRAIN is ignored
        step(0, 1, 0, 0, '0, '0);
        beat(0);
        step(0, 1, 1, 0, rand_vec(), rand_vec());
        step(0, 1, 0, 0, '0, '0);
        beat(1);
        idle_n(50);
        step(0, 1, 0, 0, '0, '0);
        idle_n(DRAIN);

        // Reset mid-DRAIN, then a normal tile
        step(0, 1, 0, 0, '0, '0);
        beat(0);
        beat(0);
        beat(1);
        idle_n(100);
        step(1, 0, 0, 0, '0, '0);
        idle_n(3);
        step(0, 1, 0, 0, '0, '0);
        beat(0);
        beat(1);
        idle_n(DRAIN + 1);

        // Back-to-back: start the cycle after tile_done
        step(0, 1, 0, 0, '0, '0);
        beat(0);
        beat(0);
        beat(1);
        idle_n(DRAIN + 1);

        // Beat counter saturation with a long tile
        step(0, 1, 0, 0, '0, '0);
        for (int k = 0; k < 19; k++) beat(0);
        beat(1);
        idle_n(DRAIN + 3);

        // Randomized tiles
        for (int t = 0; t < 4; t++) random_tile($urandom_range(20, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
